// File: rtl/dmem_load_if.sv
// Load-alignment bus: MEM-stage load requests, the data-memory read word,
// and the writeback result handshake.
//   master : request/consumer side (MEM stage, memory, WB stage)
//   slave  : the load aligner
//   req_valid/req_ready       request handshake
//   req_funct3/addr_lo/rd     load type, address bits [1:0], destination tag
//   dmem_rdata                read word, valid the cycle after an accept
//   wb_valid/wb_ready         result handshake toward writeback
//   wb_data/wb_rd/wb_err      extended data, tag, misaligned/illegal flag
interface dmem_load_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [1:0]  req_addr_lo;
    logic [4:0]  req_rd;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_err;

    modport master (
        output req_valid, req_funct3, req_addr_lo, req_rd, dmem_rdata, wb_ready,
        input  req_ready, wb_valid, wb_data, wb_rd, wb_err
    );

    modport slave (
        input  req_valid, req_funct3, req_addr_lo, req_rd, dmem_rdata, wb_ready,
        output req_ready, wb_valid, wb_data, wb_rd, wb_err
    );
endinterface

// File: rtl/dmem_load_align.sv
// Load data aligner. Accepts a load request, samples the synchronous memory
// word in the following cycle, extracts and extends the addressed
// byte/half/word (or flags an error) and queues the result in a DEPTH-entry
// FIFO toward writeback.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   flush  : synchronous discard of the pending load and all queued results
//   bus    : dmem_load_if.slave (request, memory word, writeback result)
module dmem_load_align #(
    parameter int DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    dmem_load_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Pending stage: request captured at accept, memory word arrives next cycle
    logic             p_valid_reg;
    logic [2:0]       p_funct3_reg;
    logic [1:0]       p_addr_lo_reg;
    logic [4:0]       p_rd_reg;

    logic [CNT_W-1:0] count_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;

    logic [CNT_W:0]   occupancy;
    logic             accept;
    logic             wr_en;
    logic             rd_en;

    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic [31:0]      ext_data;
    logic             ext_err;

    logic [31:0]      slot_data [DEPTH];
    logic [4:0]       slot_rd   [DEPTH];
    logic             slot_err  [DEPTH];

    // The pending word counts against capacity so it always has a slot reserved.
    assign occupancy     = {1'b0, count_reg} + {{CNT_W{1'b0}}, p_valid_reg};
    assign bus.req_ready = !flush && (occupancy < (CNT_W+1)'(DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;
    assign wr_en         = p_valid_reg && !flush;
    assign rd_en         = bus.wb_valid && bus.wb_ready && !flush;

    // Lane selection and extension of the memory word for the pending load
    always_comb begin
        sel_byte = bus.dmem_rdata[8*p_addr_lo_reg +: 8];
        sel_half = p_addr_lo_reg[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        ext_data = '0;
        ext_err  = 1'b0;
        case (p_funct3_reg)
            3'b000: ext_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100: ext_data = {24'b0, sel_byte};
            3'b001, 3'b101: begin
                if (p_addr_lo_reg[0]) begin
                    ext_err = 1'b1;
                end else if (p_funct3_reg[2]) begin
                    ext_data = {16'b0, sel_half};
                end else begin
                    ext_data = {{16{sel_half[15]}}, sel_half};
                end
            end
            3'b010: begin
                if (p_addr_lo_reg != 2'b00) begin
                    ext_err = 1'b1;
                end else begin
                    ext_data = bus.dmem_rdata;
                end
            end
            default: ext_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid_reg   <= 1'b0;
            p_funct3_reg  <= '0;
            p_addr_lo_reg <= '0;
            p_rd_reg      <= '0;
        end else begin
            // accept is already blocked by flush through req_ready
            p_valid_reg <= accept;
            if (accept) begin
                p_funct3_reg  <= bus.req_funct3;
                p_addr_lo_reg <= bus.req_addr_lo;
                p_rd_reg      <= bus.req_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count_reg <= count_reg + 1'b1;
            end else if (!wr_en && rd_en) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    // One register slot per FIFO entry
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [31:0] data_reg;
        logic [4:0]  rd_reg;
        logic        err_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_reg <= '0;
                rd_reg   <= '0;
                err_reg  <= 1'b0;
            end else if (wr_en && (wr_ptr_reg == PTR_W'(gi))) begin
                data_reg <= ext_data;
                rd_reg   <= p_rd_reg;
                err_reg  <= ext_err;
            end
        end

        assign slot_data[gi] = data_reg;
        assign slot_rd[gi]   = rd_reg;
        assign slot_err[gi]  = err_reg;
    end

    // Head outputs are masked while empty so no stale entry is ever visible
    assign bus.wb_valid = (count_reg != '0);
    assign bus.wb_data  = bus.wb_valid ? slot_data[rd_ptr_reg] : '0;
    assign bus.wb_rd    = bus.wb_valid ? slot_rd[rd_ptr_reg]   : '0;
    assign bus.wb_err   = bus.wb_valid ? slot_err[rd_ptr_reg]  : 1'b0;
endmodule

// File: tb/tb_dmem_load_align.sv
// Testbench for dmem_load_align: directed table vectors, hand-written
// back-to-back / stall / flush / reset sequences, and randomized traffic,
// all checked against a queue-based reference model.
module tb_dmem_load_align;
    localparam int DEPTH = 3;

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  addr;
        logic [4:0]  rd;
        logic [31:0] word;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    dmem_load_if bus();

    dmem_load_align #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int delivered = 0;

    vec_t exp_q[$];
    vec_t pend;
    bit   pend_v = 1'b0;
    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: shift the word so the addressed item sits at bit 0, then
    // extend with plain integer arithmetic.
    function automatic void ref_load(input logic [2:0] f3, input logic [1:0] a,
                                     input logic [31:0] w,
                                     output logic [31:0] d, output logic e);
        logic [31:0] s;
        int v;
        s = w >> (8 * a);
        d = '0;
        e = 1'b0;
        case (f3)
            3'd0: begin v = int'(s & 32'hFF); if (v >= 128) v -= 256; d = v; end
            3'd4: d = s & 32'hFF;
            3'd1: if (a % 2 != 0) e = 1'b1;
                  else begin v = int'(s & 32'hFFFF); if (v >= 32768) v -= 65536; d = v; end
            3'd5: if (a % 2 != 0) e = 1'b1; else d = s & 32'hFFFF;
            3'd2: if (a != 0) e = 1'b1; else d = w;
            default: e = 1'b1;
        endcase
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.f3   = 3'($urandom_range(0, 7));
        v.addr = 2'($urandom_range(0, 3));
        v.rd   = 5'($urandom_range(0, 31));
        v.word = $urandom();
        ref_load(v.f3, v.addr, v.word, v.exp_data, v.exp_err);
        return v;
    endfunction

    // One clock cycle: drive inputs at the falling edge, check outputs against
    // the model, then advance the model across the coming rising edge.
    task automatic step(input bit rv, input vec_t v, input bit wbr, input bit fl);
        bit exp_ready;
        bit acc;
        @(negedge clk);
        bus.req_valid   = rv;
        bus.req_funct3  = v.f3;
        bus.req_addr_lo = v.addr;
        bus.req_rd      = v.rd;
        bus.wb_ready    = wbr;
        flush           = fl;
        bus.dmem_rdata  = pend_v ? pend.word : $urandom();
        #1;
        exp_ready = !fl && ((exp_q.size() + int'(pend_v)) < DEPTH);
        check("req_ready", {31'b0, bus.req_ready}, {31'b0, exp_ready});
        check("wb_valid", {31'b0, bus.wb_valid}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            check("wb_data", bus.wb_data, exp_q[0].exp_data);
            check("wb_rd", {27'b0, bus.wb_rd}, {27'b0, exp_q[0].rd});
            check("wb_err", {31'b0, bus.wb_err}, {31'b0, exp_q[0].exp_err});
        end
        acc = rv && exp_ready;
        if (acc) acc_cnt++;
        if (fl) begin
            exp_q.delete();
            pend_v = 1'b0;
        end else begin
            if (wbr && exp_q.size() != 0) begin
                $display("wb rd=%0d data=%h err=%0d", exp_q[0].rd, exp_q[0].exp_data, exp_q[0].exp_err);
                void'(exp_q.pop_front());
                delivered++;
            end
            if (pend_v) exp_q.push_back(pend);
            pend_v = acc;
            pend   = v;
        end
    endtask

    task automatic idle(input int n, input bit wbr);
        vec_t z;
        z = '{3'd0, 2'd0, 5'd0, 32'd0, 32'd0, 1'b0};
        for (int i = 0; i < n; i++) step(1'b0, z, wbr, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_wb_valid"}, {31'b0, bus.wb_valid}, 32'd0);
        check({tag, "_wb_data"}, bus.wb_data, 32'd0);
        check({tag, "_wb_rd"}, {27'b0, bus.wb_rd}, 32'd0);
        check({tag, "_wb_err"}, {31'b0, bus.wb_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int d0;
        vec_t v;

        tbl[0]  = '{3'b000, 2'd0, 5'd1,  32'h80FF7F01, 32'h00000001, 1'b0};
        tbl[1]  = '{3'b000, 2'd1, 5'd2,  32'h80FF7F01, 32'h0000007F, 1'b0};
        tbl[2]  = '{3'b000, 2'd2, 5'd3,  32'h80FF7F01, 32'hFFFFFFFF, 1'b0};
        tbl[3]  = '{3'b100, 2'd3, 5'd4,  32'h80FF7F01, 32'h00000080, 1'b0};
        tbl[4]  = '{3'b000, 2'd3, 5'd5,  32'h80FF7F01, 32'hFFFFFF80, 1'b0};
        tbl[5]  = '{3'b001, 2'd0, 5'd6,  32'h8001F00F, 32'hFFFFF00F, 1'b0};
        tbl[6]  = '{3'b101, 2'd2, 5'd7,  32'h8001F00F, 32'h00008001, 1'b0};
        tbl[7]  = '{3'b010, 2'd0, 5'd8,  32'h8001F00F, 32'h8001F00F, 1'b0};
        tbl[8]  = '{3'b010, 2'd1, 5'd9,  32'h8001F00F, 32'h00000000, 1'b1};
        tbl[9]  = '{3'b001, 2'd3, 5'd10, 32'h8001F00F, 32'h00000000, 1'b1};
        tbl[10] = '{3'b011, 2'd0, 5'd11, 32'h8001F00F, 32'h00000000, 1'b1};
        tbl[11] = '{3'b100, 2'd1, 5'd12, 32'h8001F00F, 32'h000000F0, 1'b0};

        bus.req_valid   = 1'b0;
        bus.req_funct3  = '0;
        bus.req_addr_lo = '0;
        bus.req_rd      = '0;
        bus.dmem_rdata  = '0;
        bus.wb_ready    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);

        // Table, one load at a time: result visible two cycles after accept
        for (int i = 0; i < 12; i++) begin
            step(1'b1, tbl[i], 1'b1, 1'b0);
            idle(2, 1'b1);
        end
        // Table back-to-back: errors delivered in order between legal loads
        for (int i = 0; i < 12; i++) step(1'b1, tbl[i], 1'b1, 1'b0);
        idle(3, 1'b1);

        // 20 back-to-back loads, writeback always ready
        a0 = acc_cnt;
        d0 = delivered;
        for (int i = 0; i < 20; i++) begin
            v = rand_vec();
            v.rd = 5'(i);
            step(1'b1, v, 1'b1, 1'b0);
        end
        idle(2, 1'b1);
        check("b2b_accepts", acc_cnt - a0, 20);
        check("b2b_delivered", delivered - d0, 20);

        // Stall: only DEPTH loads accepted while writeback is blocked
        a0 = acc_cnt;
        for (int i = 0; i < 6; i++) step(1'b1, rand_vec(), 1'b0, 1'b0);
        check("stall_accepts", acc_cnt - a0, DEPTH);
        d0 = delivered;
        idle(DEPTH + 1, 1'b1);
        check("stall_drained", delivered - d0, DEPTH);

        // Flush with the FIFO full (two queued, one pending) and a request present
        for (int i = 0; i < 3; i++) step(1'b1, rand_vec(), 1'b0, 1'b0);
        a0 = acc_cnt;
        step(1'b1, rand_vec(), 1'b0, 1'b1);
        check("flush_no_accept", acc_cnt - a0, 0);
        idle(3, 1'b1);

        // Reset asserted mid-stream
        for (int i = 0; i < 3; i++) step(1'b1, rand_vec(), 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        exp_q.delete();
        pend_v = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), rand_vec(),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0));
        end
        idle(DEPTH + 2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_load_align.md
# dmem_load_align

Load-side counterpart of the store byte-lane aligner: takes load requests from the MEM stage, captures the synchronous data-memory read word one cycle after each accepted request, extracts the addressed byte/halfword/word, sign- or zero-extends it, flags misaligned or illegal loads, and queues results in a small FIFO toward writeback. It sits between the MEM-stage request logic and the WB-stage register-file write port, and is the only path for load data into the pipeline.

## Interface
- DEPTH, 3, result FIFO entries; legal 2..4; 3 is the minimum for one load per cycle sustained
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous discard of all pending and queued loads
- req_valid  in  1  load request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_funct3  in  3  RV32I load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- req_addr_lo  in  2  effective address bits [1:0]
- req_rd  in  5  destination register tag
- dmem_rdata  in  32  memory read word; valid only in the cycle after an accepted request
- wb_valid  out  1  result at FIFO head
- wb_ready  in  1  writeback consumes head when wb_valid && wb_ready
- wb_data  out  32  extended load data
- wb_rd  out  5  destination tag of head entry
- wb_err  out  1  head entry is misaligned or has an illegal funct3

## Operation
- Pending stage: on accept, latch funct3, addr_lo, rd into a pending register; p_valid=1 for exactly the next cycle.
- In the p_valid cycle, dmem_rdata is decoded combinationally and written into the FIFO at the cycle's end; no other sampling of dmem_rdata.
- Byte loads: lane = addr_lo; byte = dmem_rdata[8*lane+7 : 8*lane]; LB sign-extends bit 7, LBU zero-extends.
- Half loads: addr_lo[1]=0 -> bits[15:0], 1 -> bits[31:16]; LH sign-extends bit 15, LHU zero-extends.
- LW: full word, no extension.
- Error: LH/LHU with addr_lo[0]=1, LW with addr_lo!=00, or funct3 in {011,110,111} -> entry written with wb_data=0, wb_err=1, rd kept. Errors occupy a slot and are delivered in order.
- Flow control: req_ready = !flush && (count + p_valid) < DEPTH; no combinational path from wb_ready to req_ready.
- FIFO: count 0..DEPTH; simultaneous write and read at any count (including full, via the slot freed this cycle) keeps count unchanged; order strictly preserved.
- Flush: count<=0, p_valid<=0, the in-flight word is discarded; flush overrides any concurrent accept (req_ready=0) and write.

## Timing
- Reset (async assert, sync-clean deassert): count=0, p_valid=0, pending regs=0, FIFO storage=0; wb_valid=0, wb_data=0, wb_rd=0, wb_err=0; req_ready=1 once rst_n is high.
- Latency: accept in cycle n -> dmem_rdata used in n+1 -> wb_valid with data in n+2 when the FIFO was empty.
- Throughput: one load per cycle sustained with DEPTH>=3 and wb_ready held high.
- wb_data/wb_rd/wb_err driven from FIFO head registers; stable while wb_valid && !wb_ready.
- Full FIFO: req_ready falls once count + p_valid reaches DEPTH; no entry is ever dropped, since a pending word always has a reserved slot.
- Reset mid-operation: all pending and queued loads lost; no stale wb_valid after reset.

## Test plan
- LB/LBU all four lanes, dmem_rdata=0x80FF7F01: LB lane0 -> 0x00000001, lane1 -> 0x0000007F, lane2 -> 0xFFFFFFFF, LBU lane3 -> 0x00000080, each at n+2.
- LH addr 00 / LHU addr 10 with dmem_rdata=0x8001F00F: 0xFFFFF00F, 0x00008001; LW addr 00 -> 0x8001F00F, err=0.
- Misaligned LW addr 01, LH addr 11, funct3=011: wb_data=0, wb_err=1, correct wb_rd, in order with legal neighbours.
- 20 back-to-back loads with wb_ready=1: req_ready stays 1, 20 results on consecutive cycles, tags in order.
- wb_ready=0 for 6 cycles with req_valid=1: exactly DEPTH loads accepted, req_ready=0 afterwards, head held stable; release -> all DEPTH delivered in order, then req_ready returns to 1.
- flush with full FIFO and p_valid=1 concurrent with req_valid: next cycle wb_valid=0, count=0, that request not accepted; rst_n low mid-stream -> all outputs 0 immediately.
